// File: rtl/lcd_text_scheduler.sv
// 2xCOLS character frame buffer with per-cell dirty bits, pushing changed cells to LCD_Controller.
// Optional registered readback port enabled by LCD_TEXT_SCHEDULER_READBACK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a dirty cell while the LCD is not busy
// S_REQ     | start raised, waiting for busy to rise (ack timer running)
// S_WAIT    | LCD accepted the cell, waiting for busy to fall
module lcd_text_scheduler #(
    parameter int          COLS        = 16,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20,
    parameter int          ACK_TIMEOUT = 64,
    localparam int         NCELL       = 2 * COLS,
    localparam int         IW          = $clog2(NCELL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_char,
    input  logic          i_clear,
    input  logic [IW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_char,
    output logic          o_lcd_start,
    output logic [7:0]    o_lcd_char,
    output logic [7:0]    o_lcd_addr,
    input  logic          i_lcd_busy,
    output logic          o_idle,
    output logic          o_sent,
    output logic          o_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       cell_mem [NCELL];
    logic [NCELL-1:0] dirty;
    logic [IW-1:0]    last;
    logic [TW-1:0]    timer;
    logic             found;
    logic [IW-1:0]    sel;
    int               scan;

    function automatic logic in_range(input logic [IW-1:0] idx);
        return int'(idx) < NCELL;
    endfunction

    function automatic logic [7:0] cell_addr(input logic [IW-1:0] idx);
        if (int'(idx) < COLS)
            return 8'(idx);
        else
            return 8'(int'(idx) - COLS + 'h40);
    endfunction

    // Round-robin: first dirty cell after the one most recently sent.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        scan  = 0;
        for (int k = 0; k < NCELL; k++) begin
            scan = (int'(last) + 1 + k) % NCELL;
            if (!found && dirty[IW'(scan)]) begin
                found = 1'b1;
                sel   = IW'(scan);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NCELL; k++) cell_mem[k] <= BLANK_CHAR;
            dirty       <= '1;
            state       <= S_IDLE;
            o_lcd_start <= 1'b0;
            o_lcd_char  <= BLANK_CHAR;
            o_lcd_addr  <= 8'h00;
            o_idle      <= 1'b0;
            o_sent      <= 1'b0;
            o_err       <= 1'b0;
            last        <= IW'(NCELL - 1);
            timer       <= '0;
        end else begin
            o_sent <= 1'b0;
            o_err  <= 1'b0;
            o_idle <= (state == S_IDLE) && !found && !i_wr_en && !i_clear;

            case (state)
                S_IDLE: begin
                    if (!i_lcd_busy && found) begin
                        o_lcd_char  <= cell_mem[sel];
                        o_lcd_addr  <= cell_addr(sel);
                        dirty[sel]  <= 1'b0;
                        last        <= sel;
                        timer       <= TW'(ACK_TIMEOUT - 1);
                        o_lcd_start <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_lcd_busy) begin
                        o_lcd_start <= 1'b0;
                        state       <= S_WAIT;
                    end else if (timer == '0) begin
                        o_lcd_start <= 1'b0;
                        dirty[last] <= 1'b1;
                        o_err       <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!i_lcd_busy) begin
                        o_sent <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    o_lcd_start <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase

            // Later assignments win: clear, then a same-cycle write, both override the dirty clear above.
            if (i_clear) begin
                for (int k = 0; k < NCELL; k++) cell_mem[k] <= BLANK_CHAR;
                dirty <= '1;
            end
            if (i_wr_en && in_range(i_wr_idx)) begin
                cell_mem[i_wr_idx] <= i_wr_char;
                dirty[i_wr_idx]    <= 1'b1;
            end
        end
    end

`ifdef LCD_TEXT_SCHEDULER_READBACK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_rd_char <= BLANK_CHAR;
        else if (in_range(i_rd_idx))
            o_rd_char <= cell_mem[i_rd_idx];
        else
            o_rd_char <= BLANK_CHAR;
    end
`else
    logic unused_rd;
    assign unused_rd = ^i_rd_idx;
    assign o_rd_char = 8'h00;
`endif

endmodule
